// File: rtl/tdm_demux_1_8_pkg.sv
// Shared constants and state encoding for the 1:8 TDM demultiplexer.
package tdm_demux_1_8_pkg;

    localparam int NUM_CH = 8;
    localparam int SLOT_W = 3;

    localparam logic [SLOT_W-1:0] FIRST_SLOT = '0;
    localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(NUM_CH - 1);

    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } state_e;

endpackage

// File: rtl/tdm_demux_1_8_demux.sv
// 3-to-8 one-hot strobe decoder; select k drives strobe k (channel k+1).
module demux_1_8
    import tdm_demux_1_8_pkg::*;
(
    input  logic [SLOT_W-1:0] sel,
    input  logic              en,
    output logic [NUM_CH-1:0] strobe
);

    always_comb begin
        strobe = '0;
        if (en) begin
            strobe[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/tdm_demux_1_8.sv
// Frame-locked 1:8 TDM demultiplexer with shadow buffering and atomic output commit.
//   state | meaning
//   HUNT  | unlocked, waiting for a valid sample carrying fsync
//   RECV  | locked, filling shadow slots; slot 7 commits the frame
module tdm_demux_1_8
    import tdm_demux_1_8_pkg::*;
#(
    parameter int W = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W-1:0]      din,
    input  logic              din_valid,
    input  logic              fsync,
    output logic [W-1:0]      o1,
    output logic [W-1:0]      o2,
    output logic [W-1:0]      o3,
    output logic [W-1:0]      o4,
    output logic [W-1:0]      o5,
    output logic [W-1:0]      o6,
    output logic [W-1:0]      o7,
    output logic [W-1:0]      o8,
    output logic              frame_valid,
    output logic [SLOT_W-1:0] slot,
    output logic              sync_err
);

    state_e            state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [W-1:0]      shadow_q [NUM_CH];
    logic [W-1:0]      shadow_d [NUM_CH];
    logic [W-1:0]      out_q    [NUM_CH];
    logic [W-1:0]      out_d    [NUM_CH];
    logic              frame_valid_q, frame_valid_d;
    logic              sync_err_q, sync_err_d;

    logic              wr_en;
    logic [SLOT_W-1:0] wr_sel;
    logic              commit;
    logic [NUM_CH-1:0] wr_strobe;

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;
        wr_en         = 1'b0;
        wr_sel        = slot_q;
        commit        = 1'b0;

        if (din_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (fsync) begin
                        wr_en   = 1'b1;
                        wr_sel  = FIRST_SLOT;
                        slot_d  = FIRST_SLOT + 1'b1;
                        state_d = RECV;
                    end
                end
                RECV: begin
                    if (slot_q == FIRST_SLOT && !fsync) begin
                        sync_err_d = 1'b1;
                        slot_d     = FIRST_SLOT;
                        state_d    = HUNT;
                    end else if (slot_q != FIRST_SLOT && fsync) begin
                        // Resync: the new fsync sample starts a fresh frame.
                        sync_err_d = 1'b1;
                        wr_en      = 1'b1;
                        wr_sel     = FIRST_SLOT;
                        slot_d     = FIRST_SLOT + 1'b1;
                    end else begin
                        wr_en  = 1'b1;
                        slot_d = slot_q + 1'b1;
                        if (slot_q == LAST_SLOT) begin
                            commit        = 1'b1;
                            frame_valid_d = 1'b1;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    demux_1_8 u_demux (
        .sel    (wr_sel),
        .en     (wr_en),
        .strobe (wr_strobe)
    );

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            shadow_d[i] = wr_strobe[i] ? din : shadow_q[i];
            out_d[i]    = out_q[i];
        end
        // The last sample bypasses the shadow so the whole frame lands in one edge.
        if (commit) begin
            for (int i = 0; i < NUM_CH - 1; i++) begin
                out_d[i] = shadow_q[i];
            end
            out_d[NUM_CH-1] = din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= HUNT;
            slot_q        <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= '0;
                out_q[i]    <= '0;
            end
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= shadow_d[i];
                out_q[i]    <= out_d[i];
            end
        end
    end

    assign o1          = out_q[0];
    assign o2          = out_q[1];
    assign o3          = out_q[2];
    assign o4          = out_q[3];
    assign o5          = out_q[4];
    assign o6          = out_q[5];
    assign o7          = out_q[6];
    assign o8          = out_q[7];
    assign slot        = slot_q;
    assign frame_valid = frame_valid_q;
    assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_1_8.sv
// Self-checking bench for tdm_demux_1_8 (W=4): vector table, directed frames, random traffic vs a queue model.
module tb_tdm_demux_1_8;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         fsync = 1'b0;
    logic [W-1:0] o1, o2, o3, o4, o5, o6, o7, o8;
    logic         frame_valid;
    logic [2:0]   slot;
    logic         sync_err;

    tdm_demux_1_8 #(.W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .fsync       (fsync),
        .o1          (o1),
        .o2          (o2),
        .o3          (o3),
        .o4          (o4),
        .o5          (o5),
        .o6          (o6),
        .o7          (o7),
        .o8          (o8),
        .frame_valid (frame_valid),
        .slot        (slot),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: a frame is just the list of samples collected since fsync.
    bit           m_locked;
    logic [W-1:0] m_q[$];
    logic [31:0]  m_outs;
    bit           m_fv, m_se;

    typedef struct {
        bit          rst_n;
        bit          v;
        bit          fs;
        logic [3:0]  d;
        bit          exp_fv;
        bit          exp_se;
        logic [2:0]  exp_slot;
        logic [31:0] exp_outs;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(bit r, bit v, bit fs, logic [3:0] d,
                                bit fv, bit se, logic [2:0] sl, logic [31:0] o);
        vec_t t;
        t.rst_n = r; t.v = v; t.fs = fs; t.d = d;
        t.exp_fv = fv; t.exp_se = se; t.exp_slot = sl; t.exp_outs = o;
        return t;
    endfunction

    function automatic logic [31:0] dut_outs();
        return {o1, o2, o3, o4, o5, o6, o7, o8};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_update(input bit r, input bit v, input bit fs, input logic [W-1:0] d);
        m_fv = 0;
        m_se = 0;
        if (!r) begin
            m_locked = 0;
            m_q.delete();
            m_outs = '0;
        end else if (v) begin
            if (!m_locked) begin
                if (fs) begin
                    m_q = {d};
                    m_locked = 1;
                end
            end else if (m_q.size() == 0 && !fs) begin
                m_se = 1;
                m_locked = 0;
            end else if (m_q.size() != 0 && fs) begin
                m_se = 1;
                m_q = {d};
            end else begin
                m_q.push_back(d);
                if (m_q.size() == 8) begin
                    for (int i = 0; i < 8; i++) m_outs[31-4*i -: 4] = m_q[i];
                    m_fv = 1;
                    m_q.delete();
                end
            end
        end
    endtask

    // Drive inputs, take one edge, then compare DUT against the model.
    task automatic step(input bit r, input bit v, input bit fs, input logic [W-1:0] d);
        rst_n = r; din_valid = v; fsync = fs; din = d;
        @(posedge clk);
        #1;
        model_update(r, v, fs, d);
        chk("model_outs", dut_outs(), m_outs);
        chk("model_frame_valid", 32'(frame_valid), 32'(m_fv));
        chk("model_sync_err", 32'(sync_err), 32'(m_se));
        chk("model_slot", 32'(slot), 32'(m_q.size()));
    endtask

    task automatic send_frame(input logic [W-1:0] base);
        for (int i = 0; i < 8; i++) step(1, 1, i == 0, W'(base + i));
    endtask

    initial begin
        m_locked = 0;
        m_outs   = '0;
        m_fv     = 0;
        m_se     = 0;

        vecs[0]  = mk(0, 0, 0, 4'h0, 0, 0, 3'd0, 32'h0);
        vecs[1]  = mk(1, 1, 1, 4'h1, 0, 0, 3'd1, 32'h0);
        vecs[2]  = mk(1, 1, 0, 4'h2, 0, 0, 3'd2, 32'h0);
        vecs[3]  = mk(1, 1, 0, 4'h3, 0, 0, 3'd3, 32'h0);
        vecs[4]  = mk(1, 1, 0, 4'h4, 0, 0, 3'd4, 32'h0);
        vecs[5]  = mk(1, 1, 0, 4'h5, 0, 0, 3'd5, 32'h0);
        vecs[6]  = mk(1, 1, 0, 4'h6, 0, 0, 3'd6, 32'h0);
        vecs[7]  = mk(1, 1, 0, 4'h7, 0, 0, 3'd7, 32'h0);
        vecs[8]  = mk(1, 1, 0, 4'h8, 1, 0, 3'd0, 32'h12345678);
        vecs[9]  = mk(1, 0, 1, 4'hF, 0, 0, 3'd0, 32'h12345678);
        vecs[10] = mk(1, 1, 0, 4'h9, 0, 1, 3'd0, 32'h12345678);
        vecs[11] = mk(1, 1, 0, 4'hA, 0, 0, 3'd0, 32'h12345678);

        for (int i = 0; i < 12; i++) begin
            step(vecs[i].rst_n, vecs[i].v, vecs[i].fs, vecs[i].d);
            chk($sformatf("vec%0d_outs", i), dut_outs(), vecs[i].exp_outs);
            chk($sformatf("vec%0d_fv", i), 32'(frame_valid), 32'(vecs[i].exp_fv));
            chk($sformatf("vec%0d_se", i), 32'(sync_err), 32'(vecs[i].exp_se));
            chk($sformatf("vec%0d_slot", i), 32'(slot), 32'(vecs[i].exp_slot));
        end

        // Gap of 3 idle cycles between slots 3 and 4.
        step(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 1, i == 0, W'(i + 1));
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 1, 4'hF);
            chk("gap_slot_hold", 32'(slot), 32'd4);
            chk("gap_no_fv", 32'(frame_valid), 32'd0);
        end
        for (int i = 4; i < 8; i++) step(1, 1, 0, W'(i + 1));
        chk("gap_commit", dut_outs(), 32'h12345678);
        chk("gap_fv", 32'(frame_valid), 32'd1);

        // Junk before lock is dropped.
        step(0, 0, 0, 0);
        step(1, 1, 0, 4'hA);
        step(1, 1, 0, 4'hB);
        chk("hunt_slot", 32'(slot), 32'd0);
        send_frame(4'h1);
        chk("hunt_commit", dut_outs(), 32'h12345678);

        // Resync at slot 5.
        for (int i = 0; i < 5; i++) step(1, 1, i == 0, W'(i + 1));
        step(1, 1, 1, 4'h9);
        chk("resync_err", 32'(sync_err), 32'd1);
        chk("resync_slot", 32'(slot), 32'd1);
        for (int i = 1; i < 8; i++) begin
            step(1, 1, 0, W'(9 + i));
            if (i < 7) chk("resync_no_fv", 32'(frame_valid), 32'd0);
        end
        chk("resync_commit", dut_outs(), 32'h9ABCDEF0);
        chk("resync_fv", 32'(frame_valid), 32'd1);

        // Second frame missing fsync.
        send_frame(4'h3);
        chk("b2b_commit", dut_outs(), 32'h3456789A);
        step(1, 1, 0, 4'h7);
        chk("b2b_err", 32'(sync_err), 32'd1);
        for (int i = 0; i < 7; i++) step(1, 1, 0, W'(i));
        chk("b2b_hold", dut_outs(), 32'h3456789A);
        chk("b2b_hunt_slot", 32'(slot), 32'd0);

        // Reset mid-frame at slot 6.
        for (int i = 0; i < 6; i++) step(1, 1, i == 0, W'(i + 5));
        step(0, 1, 1, 4'hC);
        chk("rst_outs", dut_outs(), 32'h0);
        chk("rst_slot", 32'(slot), 32'd0);
        chk("rst_fv", 32'(frame_valid), 32'd0);
        chk("rst_se", 32'(sync_err), 32'd0);
        step(1, 1, 0, 4'h2);
        chk("rst_hunt", 32'(slot), 32'd0);
        send_frame(4'h1);
        chk("rst_commit", dut_outs(), 32'h12345678);

        // Random traffic, mostly well-framed with occasional faults and resets.
        begin
            int cnt = 0;
            for (int n = 0; n < 3000; n++) begin
                bit r, v, fs;
                r  = ($urandom_range(0, 149) != 0);
                v  = ($urandom_range(0, 3) != 0);
                fs = ((cnt % 8) == 0) ^ ($urandom_range(0, 24) == 0);
                step(r, v, fs, W'($urandom));
                if (v) cnt++;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tdm_demux_1_8.md
TDM_DEMUX_1_8 -- requirements
Module: tdm_demux_1_8

Interface
REQ-001 SHALL have parameter W, default 1, width in bits of each channel sample.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port din  input  W  serial time-division sample stream.
REQ-005 SHALL have port din_valid  input  1  din carries a sample this cycle.
REQ-006 SHALL have port fsync  input  1  marks the sample on din as slot 0 of a frame; qualified by din_valid.
REQ-007 SHALL have ports o1..o8  output  W each  demultiplexed channel samples, slots 0..7 respectively.
REQ-008 SHALL have port frame_valid  output  1  one-cycle pulse when o1..o8 are updated.
REQ-009 SHALL have port slot  output  3  index of the slot the next accepted sample will fill.
REQ-010 SHALL have port sync_err  output  1  one-cycle pulse on a framing violation.

Function
REQ-011 SHALL implement two states: HUNT (unlocked) and RECV (locked).
REQ-012 SHALL accept a sample only in a cycle with din_valid=1; with din_valid=0 all state, slot and shadow contents SHALL hold.
REQ-013 SHALL ignore fsync when din_valid=0.
REQ-014 In HUNT, samples without fsync SHALL be discarded; din_valid=1 with fsync=1 SHALL store din as slot 0, set slot to 1 and enter RECV.
REQ-015 In RECV, each accepted sample SHALL be written to shadow register [slot], and slot SHALL increment modulo 8.
REQ-016 An accepted sample at slot 7 SHALL copy shadow slots 0..6 plus that sample into o1..o8 in a single cycle. o1..o8 and frame_valid=1 SHALL be visible the cycle after acceptance. slot SHALL wrap to 0 and the state SHALL remain RECV.
REQ-017 o1..o8 SHALL hold their values between commits; a partial frame SHALL never reach the outputs.
REQ-018 In RECV at slot 0, an accepted sample with fsync=1 is normal and SHALL follow REQ-015.
REQ-019 In RECV at slot 0, an accepted sample with fsync=0 SHALL pulse sync_err, discard the sample, set slot to 0 and return to HUNT.
REQ-020 In RECV at slot 1..7, an accepted sample with fsync=1 SHALL pulse sync_err, discard the partial frame, store din as slot 0, set slot to 1 and stay in RECV (resync).
REQ-021 sync_err and frame_valid SHALL be registered and pulse for exactly one cycle.
REQ-022 Latency SHALL be 1 cycle from acceptance of the slot-7 sample to frame_valid.

Reset
REQ-023 While rst_n=0 at a clock edge, the block SHALL enter HUNT and clear slot, the shadow registers, o1..o8, frame_valid and sync_err to 0.
REQ-024 Reset mid-frame SHALL discard the partial frame with no frame_valid or sync_err pulse.
REQ-025 Reset SHALL take priority over every other input in the same cycle.

Structure
REQ-026 Shared package SHALL hold the constants NUM_CH=8 and SLOT_W=3 and the state encoding HUNT/RECV.
REQ-027 A combinational sub-module demux_1_8 (3-bit select, 1-bit enable, 8 one-hot write strobes) SHALL drive the shadow-register write enables.
REQ-028 The channel mapping SHALL be the inverse of the team's 8:1 mux: select value k corresponds to channel k+1.

Verification (W=4)
REQ-029 Reset, then a contiguous frame 1..8 with fsync on the first sample -> frame_valid one cycle after the 8th sample, o1..o8=1..8, sync_err=0.
REQ-030 Same frame with din_valid deasserted 3 cycles between slots 3 and 4 -> identical outputs; frame_valid delayed by 3 cycles; slot holds at 4 during the gap.
REQ-031 Samples A,B before any fsync, then a valid frame 1..8 -> A and B dropped, o1..o8=1..8.
REQ-032 fsync asserted again at slot 5 of frame 1..8, followed by 9..F,0 -> sync_err pulse at slot 5, no frame_valid for the partial frame, next commit o1..o8=9,A,B,C,D,E,F,0.
REQ-033 Two back-to-back frames, second with fsync=0 on its first sample -> first frame committed, sync_err pulse, HUNT entered, o1..o8 unchanged.
REQ-034 rst_n=0 for 1 cycle at slot 6 -> all outputs 0, slot=0, HUNT; a following frame 1..8 commits correctly.
